// File: rtl/rr_mux4to1_if.sv
// Handshake bundle for the 4-to-1 round-robin multiplexer: four producer
// lanes in, one tagged consumer lane out.
interface rr_mux4to1_if #(
    parameter int DATA_W = 8
);
    logic [3:0]          in_valid;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_sel;
    logic                out_ready;

    // Producer/consumer side drives the requests and the downstream ready.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    // The multiplexer itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_mux4to1.sv
// Round-robin 4-to-1 multiplexer with a single registered output stage;
// each output word carries the index of the channel it came from.
module rr_mux4to1 #(
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_mux4to1_if.slave  bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state;
    logic                valid_reg;
    logic [DATA_W-1:0]   data_reg;
    logic [1:0]          sel_reg;
    logic [1:0]          ptr;

    logic [DATA_W-1:0]   words [4];
    logic [1:0]          grant;
    logic [1:0]          idx;
    logic                grant_valid;
    logic                load;

    for (genvar k = 0; k < 4; k++) begin : g_words
        assign words[k] = bus.in_data[k*DATA_W +: DATA_W];
    end

    // Scan from the farthest offset down so the channel nearest ptr wins.
    always_comb begin
        grant       = 2'd0;
        grant_valid = 1'b0;
        idx         = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (bus.in_valid[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

    assign load = (state == EMPTY) | (valid_reg & bus.out_ready);

    // Gated by rst_n so no producer sees an accept while reset is held.
    assign bus.in_ready = (rst_n && load && grant_valid) ? (4'b0001 << grant) : 4'b0000;

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            valid_reg <= 1'b0;
            data_reg  <= '0;
            sel_reg   <= 2'd0;
            ptr       <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (grant_valid) begin
                        state     <= FULL;
                        valid_reg <= 1'b1;
                        data_reg  <= words[grant];
                        sel_reg   <= grant;
                        ptr       <= grant + 2'd1;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        if (grant_valid) begin
                            data_reg <= words[grant];
                            sel_reg  <= grant;
                            ptr      <= grant + 2'd1;
                        end else begin
                            // Drained with nothing to replace it: data/sel keep their last values.
                            state     <= EMPTY;
                            valid_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= EMPTY;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = valid_reg;
    assign bus.out_data  = data_reg;
    assign bus.out_sel   = sel_reg;
endmodule

// File: tb/tb_rr_mux4to1.sv
// Self-checking bench for rr_mux4to1: a reference arbiter model feeds a
// scoreboard of accepted words that is compared against the output register.
module tb_rr_mux4to1;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [1:0]        sel;
        logic [DATA_W-1:0] data;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_mux4to1_if #(.DATA_W(DATA_W)) bus ();

    rr_mux4to1 #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int                n_checks = 0;
    int                n_errors = 0;
    logic [DATA_W-1:0] chan [4];
    word_t             sb [$];
    logic              m_full;
    logic [1:0]        m_ptr;
    word_t             m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Winner is the requesting channel at the smallest rotational distance from ptr.
    function automatic int model_grant(input logic [3:0] v, input logic [1:0] p);
        int best;
        int best_d;
        int d;
        best   = -1;
        best_d = 5;
        for (int k = 0; k < 4; k++) begin
            if (v[k]) begin
                d = (k - int'(p) + 4) % 4;
                if (d < best_d) begin
                    best_d = d;
                    best   = k;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_ptr  = 2'd0;
        m_last = '0;
        sb.delete();
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int         g;
        logic       load;
        logic       ordy;
        logic [3:0] exp_rdy;
        bus.in_data = {chan[3], chan[2], chan[1], chan[0]};
        @(negedge clk);
        ordy    = bus.out_ready;
        load    = !m_full || ordy;
        g       = model_grant(bus.in_valid, m_ptr);
        exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(m_full));
        if (m_full) begin
            chk("out_data", 32'(bus.out_data), 32'(sb[0].data));
            chk("out_sel", 32'(bus.out_sel), 32'(sb[0].sel));
        end else begin
            chk("hold_data", 32'(bus.out_data), 32'(m_last.data));
            chk("hold_sel", 32'(bus.out_sel), 32'(m_last.sel));
        end
        @(posedge clk);
        if (m_full && ordy) begin
            m_last = sb.pop_front();
            m_full = 1'b0;
        end
        if (load && g >= 0) begin
            sb.push_back({2'(g), chan[g]});
            m_full = 1'b1;
            m_ptr  = 2'(g + 1);
        end
        #1;
    endtask

    initial begin
        // Reset with random inputs on the bus
        rst_n         = 1'b0;
        bus.in_valid  = 4'($urandom);
        bus.out_ready = 1'($urandom);
        for (int k = 0; k < 4; k++) chan[k] = 8'($urandom);
        bus.in_data   = {chan[3], chan[2], chan[1], chan[0]};
        model_reset();
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_data", 32'(bus.out_data), 32'd0);
            chk("rst_out_sel", 32'(bus.out_sel), 32'd0);
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid = 4'($urandom);
        end
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) cycle();

        // Single channel 2
        chan[2]      = 8'hA5;
        bus.in_valid = 4'b0100;
        bus.in_data  = {chan[3], chan[2], chan[1], chan[0]};
        #1 chk("single_in_ready", 32'(bus.in_ready), 32'h4);
        cycle();
        bus.in_valid = 4'b0000;
        cycle();
        chk("single_model_ptr", 32'(m_ptr), 32'd3);
        cycle();

        // Round robin from a fresh reset
        #2 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chan[0] = 8'h10; chan[1] = 8'h21; chan[2] = 8'h32; chan[3] = 8'h43;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        repeat (10) cycle();
        bus.in_valid = 4'b0000;
        repeat (2) cycle();

        // Backpressure holding a ch1 word while ch3 waits
        chan[1]       = 8'h5A;
        chan[3]       = 8'hC3;
        bus.in_valid  = 4'b0010;
        bus.out_ready = 1'b0;
        cycle();
        bus.in_valid = 4'b1000;
        repeat (3) cycle();
        chk("bp_hold_sel", 32'(bus.out_sel), 32'd1);
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 4'b0000;
        cycle();
        cycle();

        // Fairness across the wrap: ch2 first sets ptr to 3
        chan[0]      = 8'h0F;
        chan[2]      = 8'h2F;
        bus.in_valid = 4'b0100;
        cycle();
        bus.in_valid = 4'b1001;
        repeat (4) cycle();
        bus.in_valid = 4'b0000;
        repeat (2) cycle();

        // Reset asserted mid-stream with a stalled full register
        chan[1]       = 8'h77;
        bus.in_valid  = 4'b0010;
        bus.out_ready = 1'b0;
        cycle();
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) chan[k] = 8'(8'hE0 + k);
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        bus.in_data   = {chan[3], chan[2], chan[1], chan[0]};
        #1 chk("post_rst_grant", 32'(bus.in_ready), 32'h1);
        repeat (3) cycle();

        // Random traffic with random backpressure
        for (int n = 0; n < 300; n++) begin
            bus.in_valid  = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) chan[k] = 8'($urandom);
            cycle();
        end
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b1;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
